// File: rtl/c_neuron_seq.sv
// Sequencer for a c_neuron bank: weight-load strobe, accumulator clear, 15-sample lockstep stream, result capture.
// Result is returned on a valid/ready port; input stalls and output backpressure hold the job in place.
module c_neuron_seq #(
   parameter int NUM_NEURONS = 8,
   parameter int VEC_LEN     = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   abort,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic                   in_valid,
   input  logic [8:0]             in_data,
   output logic                   in_ready,
   output logic                   n_z,
   output logic                   n_en,
   output logic                   n_wr_weights,
   output logic [8:0]             n_d,
   input  logic [NUM_NEURONS-1:0] n_q,
   output logic                   out_valid,
   output logic [NUM_NEURONS-1:0] out_q,
   input  logic                   out_ready,
   output logic                   busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ZERO,
      S_RUN,
      S_CAPTURE,
      S_OUT
   } state_t;

   localparam logic [3:0] LP_LAST = 4'(VEC_LEN - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [3:0]             r_cnt;
   logic [3:0]             w_cnt_nxt;
   logic [NUM_NEURONS-1:0] r_out_q;
   logic                   w_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_out_q <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (r_state == S_CAPTURE && !abort) begin
            r_out_q <= n_q;
         end
      end
   end

   // A sample is only consumed while the job is alive; a cancelling cycle takes nothing.
   assign w_take = (r_state == S_RUN) && in_valid && !abort;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (cfg_valid) begin
               w_state_nxt = S_LOAD;
            end else if (in_valid) begin
               w_state_nxt = S_ZERO;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_IDLE;
         end
         S_ZERO: begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_take) begin
               w_cnt_nxt = r_cnt + 4'd1;
               if (r_cnt == LP_LAST) begin
                  w_state_nxt = S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            w_state_nxt = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               w_state_nxt = in_valid ? S_ZERO : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (abort) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_comb begin
      cfg_ready    = 1'b0;
      in_ready     = 1'b0;
      n_z          = 1'b0;
      n_en         = 1'b0;
      n_wr_weights = 1'b0;
      n_d          = 9'd0;
      out_valid    = 1'b0;
      busy         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: cfg_ready    = 1'b1;
         S_LOAD: n_wr_weights = 1'b1;
         S_ZERO: n_z          = 1'b1;
         S_RUN: begin
            in_ready = 1'b1;
            n_en     = w_take;
            n_d      = in_data;
         end
         S_OUT:   out_valid = 1'b1;
         default: ;
      endcase
   end

   assign out_q = r_out_q;

endmodule

// File: tb/tb_c_neuron_seq.sv
// Directed bench for c_neuron_seq; n_q is driven as a per-cycle pattern so capture timing is visible in out_q.
module tb_c_neuron_seq;

   logic       clk;
   logic       rst_n;
   logic       abort;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       in_valid;
   logic [8:0] in_data;
   logic       in_ready;
   logic       n_z;
   logic       n_en;
   logic       n_wr_weights;
   logic [8:0] n_d;
   logic [7:0] n_q;
   logic       out_valid;
   logic [7:0] out_q;
   logic       out_ready;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int g     = 0;
   logic [8:0] samp [15];

   c_neuron_seq #(.NUM_NEURONS(8), .VEC_LEN(15)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .n_z(n_z), .n_en(n_en), .n_wr_weights(n_wr_weights), .n_d(n_d),
      .n_q(n_q), .out_valid(out_valid), .out_q(out_q), .out_ready(out_ready),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       cv, iv, ab, ordy;
      logic [8:0] d;
      logic       z, en, wr, cr, ir, ov, bz;
      logic [8:0] nd;
   } vec_t;

   vec_t tbl [11];

   function automatic logic [7:0] fq(input int x);
      return 8'(x * 37 + 11);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      g++;
      n_q = fq(g);
   endtask

   task automatic drive(input logic cv, input logic iv, input logic [8:0] d,
                        input logic ab, input logic ordy);
      cfg_valid = cv;
      in_valid  = iv;
      in_data   = d;
      abort     = ab;
      out_ready = ordy;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, ".n_z"}, n_z, 0);
      chk({tag, ".n_en"}, n_en, 0);
      chk({tag, ".n_wr"}, n_wr_weights, 0);
      chk({tag, ".n_d"}, n_d, 0);
      chk({tag, ".out_valid"}, out_valid, 0);
      chk({tag, ".out_q"}, out_q, 0);
      chk({tag, ".in_ready"}, in_ready, 0);
      chk({tag, ".cfg_ready"}, cfg_ready, 1);
      chk({tag, ".busy"}, busy, 0);
   endtask

   // Starts in IDLE, streams samp[] from cycle 0; returns positioned in the first OUT cycle (not ticked).
   task automatic run_vec(input string tag, input bit stall, output logic [7:0] expq);
      int idx;
      int last;
      bit gap;
      logic [7:0] cap;
      idx  = 0;
      last = stall ? 22 : 16;
      cap  = 8'h0;
      for (int i = 0; i < 15; i++) samp[i] = 9'($urandom);
      for (int c = 0; c <= last + 2; c++) begin
         gap = stall && ((c >= 6 && c <= 8) || (c >= 16 && c <= 18));
         drive(0, (c <= last) && !gap, (idx < 15) ? samp[idx] : 9'd0, 0, 0);
         #1;
         if (c == last + 1) cap = fq(g);
         chk($sformatf("%s.c%0d.n_z", tag, c), n_z, c == 1);
         chk($sformatf("%s.c%0d.n_en", tag, c), n_en, (c >= 2) && in_valid);
         chk($sformatf("%s.c%0d.in_ready", tag, c), in_ready, (c >= 2) && (c <= last));
         chk($sformatf("%s.c%0d.n_d", tag, c), n_d, ((c >= 2) && (c <= last)) ? in_data : 9'd0);
         chk($sformatf("%s.c%0d.out_valid", tag, c), out_valid, c == last + 2);
         if (c >= 2 && in_valid) idx++;
         if (c == last + 2) begin
            chk({tag, ".samples"}, idx, 15);
            chk({tag, ".out_q"}, out_q, cap);
         end else begin
            tick();
         end
      end
      expq = cap;
   endtask

   initial begin
      logic [7:0] eq;
      rst_n = 1'b0;
      n_q   = fq(0);
      drive(0, 0, 9'd0, 0, 0);

      tbl[0]  = '{1, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 0, 9'h000};
      tbl[1]  = '{0, 0, 0, 0, 9'h000, 0, 0, 1, 0, 0, 0, 1, 9'h000};
      tbl[2]  = '{0, 1, 0, 0, 9'h0A5, 0, 0, 0, 1, 0, 0, 0, 9'h000};
      tbl[3]  = '{0, 1, 0, 0, 9'h0A5, 1, 0, 0, 0, 0, 0, 1, 9'h000};
      tbl[4]  = '{0, 0, 0, 0, 9'h0A5, 0, 0, 0, 0, 1, 0, 1, 9'h0A5};
      tbl[5]  = '{0, 1, 0, 0, 9'h155, 0, 1, 0, 0, 1, 0, 1, 9'h155};
      tbl[6]  = '{1, 1, 0, 0, 9'h1FF, 0, 1, 0, 0, 1, 0, 1, 9'h1FF};
      tbl[7]  = '{0, 1, 1, 0, 9'h003, 0, 0, 0, 0, 1, 0, 1, 9'h003};
      tbl[8]  = '{0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 0, 9'h000};
      tbl[9]  = '{1, 0, 1, 0, 9'h000, 0, 0, 0, 1, 0, 0, 0, 9'h000};
      tbl[10] = '{0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 0, 9'h000};

      #3;
      chk_rst("reset");
      #9;
      rst_n = 1'b1;
      tick();
      chk_rst("post_reset");

      // Config, short job with stall, abort mid-RUN, abort overriding config.
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].cv, tbl[i].iv, tbl[i].d, tbl[i].ab, tbl[i].ordy);
         #1;
         chk($sformatf("tbl%0d.n_z", i), n_z, tbl[i].z);
         chk($sformatf("tbl%0d.n_en", i), n_en, tbl[i].en);
         chk($sformatf("tbl%0d.n_wr", i), n_wr_weights, tbl[i].wr);
         chk($sformatf("tbl%0d.cfg_ready", i), cfg_ready, tbl[i].cr);
         chk($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].ir);
         chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].ov);
         chk($sformatf("tbl%0d.busy", i), busy, tbl[i].bz);
         chk($sformatf("tbl%0d.n_d", i), n_d, tbl[i].nd);
         tick();
      end

      // Full vector, accepted immediately, back to IDLE.
      run_vec("full", 0, eq);
      drive(0, 0, 9'd0, 0, 1);
      #1;
      chk("full.accept_ov", out_valid, 1);
      tick();
      drive(0, 0, 9'd0, 0, 0);
      #1;
      chk("full.idle_cr", cfg_ready, 1);
      chk("full.idle_ov", out_valid, 0);
      chk("full.out_q_hold", out_q, eq);
      tick();

      // Stalled vector, then output backpressure with config ignored.
      run_vec("stall", 1, eq);
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, 9'd0, 0, 0);
         #1;
         chk($sformatf("bp%0d.out_valid", k), out_valid, 1);
         chk($sformatf("bp%0d.out_q", k), out_q, eq);
         chk($sformatf("bp%0d.n_wr", k), n_wr_weights, 0);
         tick();
      end
      drive(0, 1, 9'h011, 0, 1);
      #1;
      chk("b2b.ov", out_valid, 1);
      tick();
      drive(0, 1, 9'h011, 0, 0);
      #1;
      chk("b2b.n_z", n_z, 1);
      chk("b2b.out_valid", out_valid, 0);
      tick();
      drive(0, 0, 9'd0, 1, 0);
      tick();
      drive(0, 0, 9'd0, 0, 0);
      #1;
      chk("b2b.abort_idle", cfg_ready, 1);
      tick();

      // Abort after sample 7, then a clean vector.
      for (int c = 0; c <= 8; c++) begin
         drive(0, 1, 9'(c + 3), 0, 0);
         tick();
      end
      drive(0, 0, 9'd0, 1, 0);
      #1;
      chk("abort.in_ready", in_ready, 1);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 9'd0, 0, 0);
         #1;
         chk($sformatf("abort%0d.busy", k), busy, 0);
         chk($sformatf("abort%0d.n_en", k), n_en, 0);
         chk($sformatf("abort%0d.out_valid", k), out_valid, 0);
         tick();
      end
      run_vec("clean", 0, eq);
      drive(0, 0, 9'd0, 0, 1);
      tick();

      // Async reset mid-RUN.
      for (int c = 0; c <= 4; c++) begin
         drive(0, 1, 9'h07F, 0, 0);
         if (c < 4) tick();
      end
      #1;
      chk("rst_run.pre_en", n_en, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_rst("rst_run");
      tick();
      rst_n = 1'b1;
      drive(0, 0, 9'd0, 0, 0);
      tick();

      // Async reset mid-OUT.
      run_vec("pre_rst", 0, eq);
      #2;
      rst_n = 1'b0;
      #1;
      drive(0, 0, 9'd0, 0, 0);
      #1;
      chk_rst("rst_out");
      tick();
      rst_n = 1'b1;

      // Config and input in the same IDLE cycle: LOAD first, then ZERO.
      drive(1, 1, 9'h044, 0, 0);
      #1;
      chk("prio.c0_cr", cfg_ready, 1);
      tick();
      drive(0, 1, 9'h044, 0, 0);
      #1;
      chk("prio.c1_wr", n_wr_weights, 1);
      chk("prio.c1_z", n_z, 0);
      tick();
      #1;
      chk("prio.c2_cr", cfg_ready, 1);
      chk("prio.c2_wr", n_wr_weights, 0);
      tick();
      #1;
      chk("prio.c3_z", n_z, 1);
      drive(0, 0, 9'd0, 1, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/c_neuron_seq.md
# c_neuron_seq

Sequencer for a bank of `c_neuron` instances sharing one serial input stream. It pulses weight loads on request and zeroes the accumulators before each vector. It then streams exactly 15 signed 9-bit inputs into all neurons in lockstep and captures the bank's 1-bit outputs into a result word returned over a valid/ready handshake. It sits between the input-vector buffer and the neuron bank in the classifier datapath.

## Interface
- `NUM_NEURONS`, default 8: number of neurons driven in parallel, and the width of `n_q` and `out_q`.
- `VEC_LEN`, default 15: inputs per vector. Must match the neuron input count.
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `abort`, input, 1: synchronous job cancel.
- `cfg_valid`, input, 1: request to latch the externally presented weights and biases.
- `cfg_ready`, output, 1: high only in IDLE.
- `in_valid`, input, 1: an input sample is present on `in_data`.
- `in_data`, input, 9: signed input sample.
- `in_ready`, output, 1: high only in RUN.
- `n_z`, output, 1: neuron accumulator/count clear.
- `n_en`, output, 1: neuron accumulate enable.
- `n_wr_weights`, output, 1: neuron weight write strobe.
- `n_d`, output, 9: sample broadcast to every neuron.
- `n_q`, input, NUM_NEURONS: neuron outputs. Bit i comes from neuron i.
- `out_valid`, output, 1: result available.
- `out_q`, output, NUM_NEURONS: captured neuron outputs.
- `out_ready`, input, 1: consumer accepts the result.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, ZERO, RUN, CAPTURE, OUT.
- IDLE
  - `cfg_valid` → LOAD. Config has priority over input.
  - Otherwise, `in_valid` → ZERO. No sample is consumed here; `in_ready` is 0.
- LOAD
  - `n_wr_weights`=1 for exactly one cycle, then → IDLE.
  - The weight source must hold the weight and bias values stable through the LOAD cycle.
- ZERO
  - `n_z`=1 for exactly one cycle.
  - Clears the 4-bit sample counter `cnt` to 0, then → RUN.
- RUN
  - `in_ready`=1.
  - `n_en` = `in_valid`; `n_d` = `in_data`, combinational pass-through. Outside RUN, `n_d` = 0.
  - Each cycle with `in_valid`=1, `cnt` increments.
  - When `cnt`==VEC_LEN-1 and `in_valid`=1 (the last sample) → CAPTURE.
  - If `in_valid`=0: `n_en`=0, the neurons hold, `cnt` holds, and the state stays RUN. There is no timeout.
- CAPTURE
  - One cycle, no neuron strobes.
  - `out_q` <= `n_q` at the end of the cycle, then → OUT.
- OUT
  - `out_valid`=1; `out_q` holds stable until accepted.
  - On `out_ready`=1:
    - with `in_valid`=1 → ZERO (back-to-back vector);
    - otherwise → IDLE.
  - `cfg_valid` is ignored in OUT.
- `abort`=1 in any state → IDLE next cycle, overriding every other transition.
  - All strobes drop in that cycle's next state.
  - `out_valid` drops; the in-flight result is discarded.
  - Neuron contents are left as-is; the next job re-zeroes them.
- Exactly one of `n_z`, `n_en`, `n_wr_weights` is high in any cycle, or none.

## Timing
- Reset (async, `rst_n`=0) → state IDLE, `cnt`=0.
- Output values during and after reset until the first transition:
  - `n_z`=`n_en`=`n_wr_weights`=0, `n_d`=0;
  - `out_valid`=0, `out_q`=0;
  - `in_ready`=0, `cfg_ready`=1, `busy`=0.
- Reset mid-job: the job is lost with no output. The neurons are not reset by this block.
- Config latency: the handshake in cycle 0 gives `n_wr_weights` high in cycle 1. `cfg_ready` is high again in cycle 2.
- Vector latency with `in_valid` continuously high and `in_data` starting at cycle 0:
  - cycle 1: ZERO;
  - cycles 2–16: RUN, 15 samples accepted;
  - cycle 17: CAPTURE;
  - cycle 18: `out_valid`=1.
- The first sample is consumed in cycle 2. The source must hold it from cycle 0, as in_valid/in_ready semantics require.
- `n_q` is sampled in CAPTURE, one full cycle after the last `n_en` edge, giving the neuron its output settling time.
- Back-to-back throughput: with `out_ready` high on the first `out_valid` cycle, a new vector's ZERO follows immediately. This gives 18 cycles per vector.
- All outputs are decoded from registered state/`cnt`, except the RUN pass-throughs `n_en` and `n_d`.

## Test plan
- **Config:** reset, `cfg_valid`=1 for one cycle → `n_wr_weights`=1 exactly one cycle later, then `cfg_ready`=1, and `n_z`/`n_en` never assert.
- **Full vector:** load random weights, stream 15 random samples with continuous `in_valid` → `n_z` pulse at cycle 1, `n_en` high cycles 2–16 with `n_d`==`in_data`, `out_valid` at cycle 18. `out_q` matches the reference model (|bias<<2 + Σd·w|, saturated to 8'hFF when bits [30:10] are nonzero, bit 7) for NUM_NEURONS=8.
- **Stalls:** drop `in_valid` for 3 cycles after samples 4 and 11 → `n_en` low during the gaps, exactly 15 `n_en` cycles total, same `out_q` as the unstalled run, `out_valid` at cycle 24.
- **Output backpressure:** hold `out_ready`=0 for 10 cycles → `out_valid` and `out_q` stable; `cfg_valid` asserted meanwhile gives no `n_wr_weights`. Raise `out_ready` with `in_valid`=1 → ZERO on the next cycle.
- **Abort:** assert `abort` after sample 7 → IDLE next cycle, `n_en`=0, no `out_valid`. A following clean vector gives the correct `out_q` (re-zeroed).
- **Async reset:** drop `rst_n` mid-RUN and mid-OUT → all outputs immediately at their reset values; after release, `cfg_valid` and `in_valid` are both raised in the same IDLE cycle → LOAD first, then ZERO.
